// File: rtl/wb_intercon_pkg.sv
// Shared types and constants for the Wishbone N-slave interconnect.
//   - state_e       : transaction FSM states (IDLE, REQ, RESP)
//   - err_cause_e   : error-capture cause codes
//   - DEF_SLV_BASE / DEF_SLV_MASK : default 5-slave SoC address map
//       slave 0 IMEM  0x0000_0000 / 0xF000_0000
//       slave 1 DMEM  0x8000_0000 / 0xF000_0000
//       slave 2 SPI   0x2000_0000 / 0xF000_0000
//       slave 3 UART  0x9000_0000 / 0xFFFF_F000
//       slave 4 GPIO  0x9000_1000 / 0xFFFF_F000
//   - first_hit()   : lowest-index hit and hit flag from a hit vector
package wb_intercon_pkg;

    localparam int unsigned MAX_SLAVES = 16;
    localparam int unsigned IDX_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_UNMAPPED = 2'b01,
        CAUSE_SLV_ERR  = 2'b10,
        CAUSE_TIMEOUT  = 2'b11
    } err_cause_e;

    localparam logic [5*32-1:0] DEF_SLV_BASE = {
        32'h9000_1000,  // GPIO
        32'h9000_0000,  // UART
        32'h2000_0000,  // SPI flash
        32'h8000_0000,  // DMEM
        32'h0000_0000   // IMEM
    };

    localparam logic [5*32-1:0] DEF_SLV_MASK = {
        32'hFFFF_F000,
        32'hFFFF_F000,
        32'hF000_0000,
        32'hF000_0000,
        32'hF000_0000
    };

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } first_hit_t;

    function automatic first_hit_t first_hit(input logic [MAX_SLAVES-1:0] hits);
        first_hit_t r;
        r = '0;
        for (int unsigned i = 0; i < MAX_SLAVES; i++) begin
            if (hits[i] && !r.hit) begin
                r.hit = 1'b1;
                r.idx = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_intercon_n_if.sv
// Bus bundle for the single-master, N-slave Wishbone interconnect.
//   master modport : view of the bus master (drives m_*_i, receives m_*_o)
//   slave  modport : view of the interconnect (target of the master,
//                    fans out to the per-slave s_*_o / s_*_i buses)
// Per-slave buses are packed; slave i occupies slice i of each vector.
interface wb_intercon_n_if #(
    parameter int unsigned NUM_SLAVES = 5,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32
);
    localparam int unsigned SEL_W = DATA_W / 8;

    logic [ADDR_W-1:0]            m_adr_i;
    logic [DATA_W-1:0]            m_dat_i;
    logic [SEL_W-1:0]             m_sel_i;
    logic                         m_we_i;
    logic                         m_cyc_i;
    logic                         m_stb_i;
    logic [DATA_W-1:0]            m_dat_o;
    logic                         m_ack_o;
    logic                         m_err_o;

    logic [NUM_SLAVES*ADDR_W-1:0] s_adr_o;
    logic [NUM_SLAVES*DATA_W-1:0] s_dat_o;
    logic [NUM_SLAVES*SEL_W-1:0]  s_sel_o;
    logic [NUM_SLAVES-1:0]        s_we_o;
    logic [NUM_SLAVES-1:0]        s_cyc_o;
    logic [NUM_SLAVES-1:0]        s_stb_o;
    logic [NUM_SLAVES*DATA_W-1:0] s_dat_i;
    logic [NUM_SLAVES-1:0]        s_ack_i;
    logic [NUM_SLAVES-1:0]        s_err_i;

    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
        input  m_dat_o, m_ack_o, m_err_o
    );

    modport slave (
        input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        input  s_dat_i, s_ack_i, s_err_i
    );
endinterface

// File: rtl/wb_addr_decode.sv
// Combinational first-hit address decoder.
//   adr_i     : address to decode
//   hit_oh_o  : one-hot of the lowest-index matching slave (0 if none)
//   idx_o     : index of that slave
//   any_hit_o : at least one slave matched
// A slave matches when (adr_i & MASK_i) == BASE_i; overlaps resolve to
// the lowest index.
module wb_addr_decode
    import wb_intercon_pkg::*;
#(
    parameter int unsigned                NUM_SLAVES = 5,
    parameter int unsigned                ADDR_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = DEF_SLV_MASK
) (
    input  logic [ADDR_W-1:0]     adr_i,
    output logic [NUM_SLAVES-1:0] hit_oh_o,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  any_hit_o
);
    logic [MAX_SLAVES-1:0] hits;
    first_hit_t            fh;

    always_comb begin
        hits = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            hits[i] = ((adr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]);
        end
        fh        = first_hit(hits);
        idx_o     = fh.idx;
        any_hit_o = fh.hit;
        hit_oh_o  = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            hit_oh_o[i] = fh.hit && (fh.idx == IDX_W'(i));
        end
    end
endmodule

// File: rtl/wb_intercon_n.sv
// Single-master, N-slave Wishbone classic interconnect with registered
// decode and a bus watchdog.
//   wb_clk_i : clock
//   wb_rst_i : synchronous active-high reset
//   bus      : wb_intercon_n_if.slave (master side m_*, per-slave s_*)
// Optional macro WB_INTERCON_ERRCAP_EN adds sticky error capture:
//   err_addr_o / err_cause_o / err_valid_o outputs, err_clr_i input.
// Each transaction: IDLE (decode + latch) -> REQ (selected slave strobed)
// -> RESP (one cycle of ack or err). Unmapped addresses go IDLE -> RESP.
module wb_intercon_n
    import wb_intercon_pkg::*;
#(
    parameter int unsigned                  NUM_SLAVES     = 5,
    parameter int unsigned                  ADDR_W         = 32,
    parameter int unsigned                  DATA_W         = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE       = DEF_SLV_BASE,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK       = DEF_SLV_MASK,
    parameter int unsigned                  TIMEOUT_CYCLES = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
`ifdef WB_INTERCON_ERRCAP_EN
    output logic [ADDR_W-1:0] err_addr_o,
    output logic [1:0]        err_cause_o,
    output logic              err_valid_o,
    input  logic              err_clr_i,
`endif
    wb_intercon_n_if.slave    bus
);
    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      sel_q, sel_d;
    logic [NUM_SLAVES-1:0] sel_oh_q, sel_oh_d;
    logic [ADDR_W-1:0]     adr_q, adr_d;
    logic [DATA_W-1:0]     dat_q, dat_d;
    logic [SEL_W-1:0]      be_q, be_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic [DATA_W-1:0]     rdat_q, rdat_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [NUM_SLAVES-1:0] dec_oh;
    logic [IDX_W-1:0]      dec_idx;
    logic                  dec_hit;
    logic                  sack, serr;
    logic [DATA_W-1:0]     sdat;

    wb_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_dec (
        .adr_i     (bus.m_adr_i),
        .hit_oh_o  (dec_oh),
        .idx_o     (dec_idx),
        .any_hit_o (dec_hit)
    );

    // Return path from the latched slave only; strays from others are ignored.
    always_comb begin
        sack = 1'b0;
        serr = 1'b0;
        sdat = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == IDX_W'(i)) begin
                sack = bus.s_ack_i[i];
                serr = bus.s_err_i[i];
                sdat = bus.s_dat_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        sel_oh_d = sel_oh_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        be_d     = be_q;
        we_d     = we_q;
        err_d    = err_q;
        rdat_d   = '0;
        cnt_d    = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                err_d = 1'b0;
                if (bus.m_cyc_i && bus.m_stb_i) begin
                    if (dec_hit) begin
                        sel_d    = dec_idx;
                        sel_oh_d = dec_oh;
                        adr_d    = bus.m_adr_i;
                        dat_d    = bus.m_dat_i;
                        be_d     = bus.m_sel_i;
                        we_d     = bus.m_we_i;
                        state_d  = ST_REQ;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_REQ: begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                // Priority: master abort, slave err, slave ack, watchdog.
                if (!bus.m_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (serr) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (sack) begin
                    rdat_d  = we_q ? '0 : sdat;
                    state_d = ST_RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            sel_oh_q <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            be_q     <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            rdat_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            sel_oh_q <= sel_oh_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            be_q     <= be_d;
            we_q     <= we_d;
            err_q    <= err_d;
            rdat_q   <= rdat_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.m_ack_o = (state_q == ST_RESP) && !err_q;
    assign bus.m_err_o = (state_q == ST_RESP) && err_q;
    assign bus.m_dat_o = rdat_q;

    // Latched request fans out to the selected slave only, and only in REQ.
    always_comb begin
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        bus.s_we_o  = '0;
        bus.s_cyc_o = '0;
        bus.s_stb_o = '0;
        if (state_q == ST_REQ) begin
            for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
                if (sel_oh_q[i]) begin
                    bus.s_adr_o[i*ADDR_W +: ADDR_W] = adr_q;
                    bus.s_dat_o[i*DATA_W +: DATA_W] = dat_q;
                    bus.s_sel_o[i*SEL_W +: SEL_W]   = be_q;
                    bus.s_we_o[i]                   = we_q;
                    bus.s_cyc_o[i]                  = 1'b1;
                    bus.s_stb_o[i]                  = 1'b1;
                end
            end
        end
    end

`ifdef WB_INTERCON_ERRCAP_EN
    logic [ADDR_W-1:0] eaddr_q, eaddr_d;
    err_cause_e        ecause_q, ecause_d;
    logic              evalid_q, evalid_d;
    logic              new_err;

    // An error is born on the transition into RESP with err set.
    always_comb begin
        eaddr_d  = eaddr_q;
        ecause_d = ecause_q;
        evalid_d = evalid_q;
        new_err  = (state_q != ST_RESP) && (state_d == ST_RESP) && err_d;
        if (err_clr_i) begin
            eaddr_d  = '0;
            ecause_d = CAUSE_NONE;
            evalid_d = 1'b0;
        end
        if (new_err && (!evalid_q || err_clr_i)) begin
            evalid_d = 1'b1;
            if (state_q == ST_IDLE) begin
                eaddr_d  = bus.m_adr_i;
                ecause_d = CAUSE_UNMAPPED;
            end else begin
                eaddr_d  = adr_q;
                ecause_d = serr ? CAUSE_SLV_ERR : CAUSE_TIMEOUT;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            eaddr_q  <= '0;
            ecause_q <= CAUSE_NONE;
            evalid_q <= 1'b0;
        end else begin
            eaddr_q  <= eaddr_d;
            ecause_q <= ecause_d;
            evalid_q <= evalid_d;
        end
    end

    assign err_addr_o  = eaddr_q;
    assign err_cause_o = ecause_q;
    assign err_valid_o = evalid_q;
`endif
endmodule
